demux_dispatch: RTL

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

---
 rtl/cpu_pkg.sv | 11 +
 rtl/demux_dispatch_if.sv | 28 ++
 rtl/dispatch_slot.sv | 38 +++
 rtl/demux_dispatch.sv | 51 +++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: bus widths and the dispatcher port count.
package cpu_pkg;
    localparam int DATABUS_SIZE   = 16;
    localparam int ADDR_BUS_WIDTH = 16;
    localparam int NUM_PORTS      = 4;
    localparam int PORT_W         = $clog2(NUM_PORTS);

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction
endpackage

// File: rtl/demux_dispatch_if.sv
// Upstream stream plus the four per-port downstream channels of the dispatcher.
interface demux_dispatch_if #(
    parameter int DATA_W = cpu_pkg::DATABUS_SIZE,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_dest;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [CNT_W-1:0]  acc_cnt0, acc_cnt1, acc_cnt2, acc_cnt3;

    modport slave (
        input  in_valid, in_dest, in_data, out_ready,
        output in_ready, out_valid,
        output out_data0, out_data1, out_data2, out_data3,
        output acc_cnt0, acc_cnt1, acc_cnt2, acc_cnt3
    );

    modport master (
        output in_valid, in_dest, in_data, out_ready,
        input  in_ready, out_valid,
        input  out_data0, out_data1, out_data2, out_data3,
        input  acc_cnt0, acc_cnt1, acc_cnt2, acc_cnt3
    );
endinterface

// File: rtl/dispatch_slot.sv
// Single-entry holding register for one output port, with its accept counter.
module dispatch_slot #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  cnt
);
    // Flush only drops the valid flag; payload stays put. Load beats drain so
    // a same-cycle drain-and-refill keeps the entry valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load && !flush)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/demux_dispatch.sv
// One-to-four dispatcher: routes each accepted word into a per-port holding slot.
module demux_dispatch
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATABUS_SIZE,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    demux_dispatch_if.slave   bus
);
    logic [NUM_PORTS-1:0]             load;
    logic [NUM_PORTS-1:0]             drain;
    logic [NUM_PORTS-1:0]             valid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt;
    logic                             accept;

    // Ready only looks at the addressed port, so a stalled port never blocks others.
    assign bus.in_ready = !flush && (!valid[bus.in_dest] || bus.out_ready[bus.in_dest]);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept ? port_onehot(bus.in_dest) : '0;
    assign drain        = valid & bus.out_ready;

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
            dispatch_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .load      (load[g]),
                .drain     (drain[g]),
                .load_data (bus.in_data),
                .valid     (valid[g]),
                .data      (data[g]),
                .cnt       (cnt[g])
            );
        end
    endgenerate

    assign bus.out_valid = valid;
    assign bus.out_data0 = data[0];
    assign bus.out_data1 = data[1];
    assign bus.out_data2 = data[2];
    assign bus.out_data3 = data[3];
    assign bus.acc_cnt0  = cnt[0];
    assign bus.acc_cnt1  = cnt[1];
    assign bus.acc_cnt2  = cnt[2];
    assign bus.acc_cnt3  = cnt[3];
endmodule
